// File: rtl/adc_128s022_emu_pkg.sv
// Shared constants, types and helpers for the ADC128S022 emulator.
//   FRAME_BITS      : SCLK periods per serial frame
//   LEAD_ZEROS      : zero bits ahead of the conversion result on DOUT
//   DATA_BITS       : conversion result width
//   ADDR_FIRST_EDGE : SCLK rising edge that captures ADD2
//   ADDR_BITS       : channel address width
//   conv_result()   : deterministic conversion value for a channel
package adc_128s022_emu_pkg;

  localparam int unsigned FRAME_BITS      = 16;
  localparam int unsigned LEAD_ZEROS      = 4;
  localparam int unsigned DATA_BITS       = 12;
  localparam int unsigned ADDR_FIRST_EDGE = 3;
  localparam int unsigned ADDR_BITS       = 3;

  typedef logic [ADDR_BITS-1:0] chan_t;

  typedef enum logic [0:0] {IDLE, FRAME} emu_state_t;

  // Emulated conversion: analog level in the top byte, channel in the low bits.
  function automatic logic [DATA_BITS-1:0] conv_result(input logic [7:0] adc_in,
                                                      input chan_t     chan);
    return {adc_in, 1'b0, chan};
  endfunction

endpackage

// File: rtl/adc_emu_sync_edge.sv
// Multi-flop synchronizer with edge detection on the synchronized level.
//   CLOCK_50 : system clock
//   reset    : asynchronous, active-high
//   sig_i    : asynchronous input
//   level_o  : synchronized level
//   rise_o   : one-cycle pulse on a synchronized 0->1 transition
//   fall_o   : one-cycle pulse on a synchronized 1->0 transition
module adc_emu_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    level_o = sync_q[SYNC_STAGES-1];
    rise_o  = level_o & ~prev_q;
    fall_o  = ~level_o & prev_q;
  end

endmodule

// File: rtl/adc_128s022_emu.sv
// Clocked emulator of the TI ADC128S022 8-channel, 12-bit SPI ADC (DE0-Nano).
//   CLOCK_50  : system clock, all state on rising edge
//   reset     : asynchronous, active-high
//   ADC_CS_N  : chip select, active low; falling edge starts a frame
//   ADC_SCLK  : serial clock from the controller, idles high
//   ADC_SADDR : DIN, sampled on ADC_SCLK rising edges
//   ADC_IN    : emulated analog level, common to all channels
//   ADC_SDAT  : DOUT, MSB first, changes after ADC_SCLK falling edges
// Build option: define ADC_EMU_TRISTATE_EN to float ADC_SDAT while CS_N is high
// or in reset; otherwise it is driven 0 there.
module adc_128s022_emu
  import adc_128s022_emu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter chan_t       FIRST_CHANNEL = 3'd0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ADC_CS_N,
  input  logic       ADC_SCLK,
  input  logic       ADC_SADDR,
  input  logic [7:0] ADC_IN,
  output logic       ADC_SDAT
);

  // DIN bit index holding ADD2 once all FRAME_BITS bits are shifted in.
  localparam int unsigned AddrMsb = FRAME_BITS - ADDR_FIRST_EDGE;

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic saddr_lvl, saddr_rise, saddr_fall;

  adc_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .sig_i    (ADC_CS_N),
    .level_o  (cs_lvl),
    .rise_o   (cs_rise),
    .fall_o   (cs_fall)
  );

  adc_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .sig_i    (ADC_SCLK),
    .level_o  (sclk_lvl),
    .rise_o   (sclk_rise),
    .fall_o   (sclk_fall)
  );

  adc_emu_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_saddr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .sig_i    (ADC_SADDR),
    .level_o  (saddr_lvl),
    .rise_o   (saddr_rise),
    .fall_o   (saddr_fall)
  );

  emu_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  chan_t                 chan_q, chan_d;
  logic [FRAME_BITS-1:0] din_q, din_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  sdat_q, sdat_d;
  // Set by the 16th rising edge: the next falling edge starts a new frame.
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] frame_word;

  assign frame_word = {{LEAD_ZEROS{1'b0}}, conv_result(ADC_IN, chan_q)};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= FIRST_CHANNEL;
      din_q   <= '0;
      shift_q <= '0;
      sdat_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      din_q   <= din_d;
      shift_q <= shift_d;
      sdat_q  <= sdat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    din_d   = din_q;
    shift_d = shift_q;
    sdat_d  = sdat_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        sdat_d = 1'b0;
        if (cs_fall) begin
          state_d = FRAME;
          shift_d = frame_word;
          sdat_d  = frame_word[FRAME_BITS-1];
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      FRAME: begin
        // CS_N release outranks any SCLK edge in the same cycle.
        if (cs_rise) begin
          state_d = IDLE;
          sdat_d  = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else if (sclk_rise) begin
          din_d = {din_q[FRAME_BITS-2:0], saddr_lvl};
          if (cnt_q == 4'(FRAME_BITS - 1)) begin
            cnt_d  = '0;
            chan_d = din_d[AddrMsb -: ADDR_BITS];
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (sclk_fall) begin
          if (cnt_q != '0) begin
            sdat_d  = shift_q[FRAME_BITS-2];
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          end else if (done_q) begin
            // Continuous mode: reload with the newly addressed channel.
            shift_d = frame_word;
            sdat_d  = frame_word[FRAME_BITS-1];
            done_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_EMU_TRISTATE_EN
  assign ADC_SDAT = (cs_lvl || reset) ? 1'bz : sdat_q;
  logic unused_sigs;
  assign unused_sigs = ^{sclk_lvl, saddr_rise, saddr_fall, din_q[FRAME_BITS-1]};
`else
  assign ADC_SDAT = sdat_q;
  logic unused_sigs;
  assign unused_sigs = ^{cs_lvl, sclk_lvl, saddr_rise, saddr_fall, din_q[FRAME_BITS-1]};
`endif

endmodule

// File: tb/tb_adc_128s022_emu.sv
module tb_adc_128s022_emu;

  localparam int unsigned H = 6;  // CLOCK_50 cycles per SCLK phase (>= SYNC_STAGES+2)
  localparam logic [2:0] FIRST_CH = 3'd0;

`ifdef ADC_EMU_TRISTATE_EN
  localparam logic IDLE_SDAT = 1'bz;
`else
  localparam logic IDLE_SDAT = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       ADC_CS_N;
  logic       ADC_SCLK;
  logic       ADC_SADDR;
  logic [7:0] ADC_IN;
  wire        ADC_SDAT;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: channel the next frame will convert.
  logic [2:0] m_chan;

  always #10 CLOCK_50 = ~CLOCK_50;

  adc_128s022_emu dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .ADC_CS_N  (ADC_CS_N),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_SADDR (ADC_SADDR),
    .ADC_IN    (ADC_IN),
    .ADC_SDAT  (ADC_SDAT)
  );

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    assert (ADC_SDAT === IDLE_SDAT) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, ADC_SDAT, IDLE_SDAT);
    end
  endtask

  // Drives n_rise SCLK periods; DOUT is sampled just before each rising edge.
  task automatic run_frame(input logic [2:0] addr, input int n_rise, input bit hold_cs,
                           input int chg_edge, input logic [7:0] chg_val,
                           output logic [15:0] got);
    got = '0;
    if (ADC_CS_N) begin
      ADC_CS_N = 1'b0;
      cycles(H);
    end
    for (int k = 1; k <= n_rise; k++) begin
      ADC_SCLK = 1'b0;
      case (k)
        3:       ADC_SADDR = addr[2];
        4:       ADC_SADDR = addr[1];
        5:       ADC_SADDR = addr[0];
        default: ADC_SADDR = 1'($urandom);
      endcase
      cycles(H);
      got[16-k] = ADC_SDAT;
      ADC_SCLK = 1'b1;
      if (k == chg_edge) ADC_IN = chg_val;
      cycles(H);
    end
    if (!hold_cs) begin
      ADC_CS_N = 1'b1;
      cycles(H);
    end
  endtask

  // Full 16-clock frame checked against the reference, then advance the model.
  task automatic full_frame(input string tag, input logic [2:0] addr, input bit hold_cs,
                            input int chg_edge, input logic [7:0] chg_val);
    logic [15:0] got;
    logic [15:0] exp;
    exp = {4'h0, ADC_IN, 1'b0, m_chan};
    run_frame(addr, 16, hold_cs, chg_edge, chg_val, got);
    check16(tag, got, exp);
    m_chan = addr;
  endtask

  initial begin
    logic [15:0] dummy;
    reset     = 1'b1;
    ADC_CS_N  = 1'b1;
    ADC_SCLK  = 1'b1;
    ADC_SADDR = 1'b0;
    ADC_IN    = 8'h00;
    m_chan    = FIRST_CH;
    cycles(3);
    check_idle("reset_sdat");
    reset = 1'b0;
    cycles(H);
    check_idle("post_reset_idle");

    // Basic frame on the reset channel.
    ADC_IN = 8'hA5;
    full_frame("a5_ch0", 3'd0, 1'b0, 0, 8'h00);
    check16("a5_ch0_const", {4'h0, 8'hA5, 1'b0, 3'd0}, 16'h0A50);

    // Address applies to the next frame.
    full_frame("addr3_frame1", 3'd3, 1'b0, 0, 8'h00);
    full_frame("addr3_frame2", 3'd0, 1'b0, 0, 8'h00);

    // Continuous mode, CS_N held low across three frames.
    ADC_IN = 8'h3C;
    full_frame("cont_f1", 3'd7, 1'b1, 0, 8'h00);
    full_frame("cont_f2", 3'd2, 1'b1, 0, 8'h00);
    full_frame("cont_f3", 3'd5, 1'b0, 0, 8'h00);
    check_idle("cont_release_idle");

    // Partial frame is discarded.
    full_frame("pre_partial", 3'd0, 1'b0, 0, 8'h00);
    run_frame(3'd6, 8, 1'b0, 0, 8'h00, dummy);
    check_idle("partial_idle");
    full_frame("after_partial", 3'd6, 1'b0, 0, 8'h00);

    // Reset mid-frame restores FIRST_CHANNEL.
    full_frame("pre_reset", 3'd5, 1'b0, 0, 8'h00);
    run_frame(3'd4, 10, 1'b1, 0, 8'h00, dummy);
    reset    = 1'b1;
    ADC_CS_N = 1'b1;
    ADC_SCLK = 1'b1;
    #1;
    check_idle("midframe_reset_sdat");
    cycles(H);
    check_idle("midframe_reset_hold");
    reset  = 1'b0;
    m_chan = FIRST_CH;
    cycles(H);
    full_frame("after_reset", 3'd0, 1'b0, 0, 8'h00);

    // ADC_IN change mid-frame only affects the following frame.
    ADC_IN = 8'h11;
    full_frame("adcin_mid_cur", 3'd0, 1'b0, 6, 8'hFF);
    full_frame("adcin_mid_next", 3'd0, 1'b0, 0, 8'h00);

    // Randomized frames, mixing single and continuous mode.
    for (int i = 0; i < 10; i++) begin
      ADC_IN = 8'($urandom);
      full_frame($sformatf("rand_%0d", i), 3'($urandom), 1'($urandom), 0, 8'h00);
    end
    ADC_CS_N = 1'b1;
    cycles(H);
    check_idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
